// File: rtl/auto_load_seq.sv
// auto_load_seq: power-on auto-load of the DCFEB configuration registers.
// Reads a header word from the BPI PROM, checks it against MAGIC, then reads
// NREGS words from BASE_ADDR+1 onward and writes each one to the config bus.
//
// BPI read handshake: RD_REQ is raised with RD_ADDR and both stay stable
// until RD_ACK is sampled high on a rising edge while RD_REQ is high; RD_DATA
// is captured on that same edge. RD_ACK seen while RD_REQ is low is ignored.
// The bench-visible state is exported on AL_STATE.
module auto_load_seq #(
  parameter int          NREGS     = 8,
  parameter logic [22:0] BASE_ADDR = 23'h7E0000,
  parameter logic [15:0] MAGIC     = 16'hA55A,
  parameter int          RD_TMO    = 255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        AL_START,
  output logic        AL_DONE,
  output logic [1:0]  AL_ERR,
  output logic [4:0]  AL_CNT,
  output logic        RD_REQ,
  output logic [22:0] RD_ADDR,
  input  logic        RD_ACK,
  input  logic [15:0] RD_DATA,
  output logic        CFG_WE,
  output logic [3:0]  CFG_ADDR,
  output logic [15:0] CFG_DATA,
  output logic [2:0]  AL_STATE
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_DAT  = 3'd2,
    S_WR   = 3'd3,
    S_DONE = 3'd4
  } state_t;

  // Last wait-counter value before the request is abandoned, so RD_REQ is
  // high for exactly RD_TMO cycles when no ack arrives.
  localparam logic [7:0] TMO_LAST = 8'(RD_TMO - 1);
  localparam logic [3:0] LAST_IDX = 4'(NREGS - 1);

  state_t      state, state_n;
  logic        done_r, done_n;
  logic [1:0]  err_r, err_n;
  logic [4:0]  cnt_r, cnt_n;
  logic        req_r, req_n;
  logic [22:0] addr_r, addr_n;
  logic        we_r, we_n;
  logic [3:0]  cfga_r, cfga_n;
  logic [15:0] cfgd_r, cfgd_n;
  logic [3:0]  idx, idx_n;
  logic [7:0]  wait_cnt, wait_n;
  logic [15:0] data_q, data_n;
  logic [3:0]  idx_inc;

  assign idx_inc = idx + 4'd1;

  // State and all registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= S_IDLE;
      done_r   <= 1'b1;
      err_r    <= 2'b00;
      cnt_r    <= 5'd0;
      req_r    <= 1'b0;
      addr_r   <= 23'd0;
      we_r     <= 1'b0;
      cfga_r   <= 4'd0;
      cfgd_r   <= 16'd0;
      idx      <= 4'd0;
      wait_cnt <= 8'd0;
      data_q   <= 16'd0;
    end else begin
      state    <= state_n;
      done_r   <= done_n;
      err_r    <= err_n;
      cnt_r    <= cnt_n;
      req_r    <= req_n;
      addr_r   <= addr_n;
      we_r     <= we_n;
      cfga_r   <= cfga_n;
      cfgd_r   <= cfgd_n;
      idx      <= idx_n;
      wait_cnt <= wait_n;
      data_q   <= data_n;
    end
  end

  // Next-state and next-output logic; everything holds unless changed, and the
  // write strobe defaults low so it is a single-cycle pulse.
  always_comb begin
    state_n = state;
    done_n  = done_r;
    err_n   = err_r;
    cnt_n   = cnt_r;
    req_n   = req_r;
    addr_n  = addr_r;
    we_n    = 1'b0;
    cfga_n  = cfga_r;
    cfgd_n  = cfgd_r;
    idx_n   = idx;
    wait_n  = wait_cnt;
    data_n  = data_q;

    unique case (state)
      S_IDLE: begin
        done_n = 1'b1;
        if (AL_START) begin
          state_n = S_HDR;
          done_n  = 1'b0;
          req_n   = 1'b1;
          addr_n  = BASE_ADDR;
          err_n   = 2'b00;
          cnt_n   = 5'd0;
          idx_n   = 4'd0;
          wait_n  = 8'd0;
        end
      end

      S_HDR, S_DAT: begin
        if (!AL_START) begin
          // Abort beats both ack and timeout.
          state_n = S_IDLE;
          done_n  = 1'b1;
          req_n   = 1'b0;
          err_n   = 2'b11;
        end else if (req_r && RD_ACK) begin
          // Ack beats a timeout landing in the same cycle.
          req_n = 1'b0;
          if (state == S_HDR) begin
            if (RD_DATA == MAGIC) begin
              state_n = S_DAT;
              req_n   = 1'b1;
              addr_n  = BASE_ADDR + 23'd1;
              wait_n  = 8'd0;
            end else begin
              state_n = S_DONE;
              done_n  = 1'b1;
              err_n   = 2'b01;
            end
          end else begin
            state_n = S_WR;
            data_n  = RD_DATA;
          end
        end else if (wait_cnt == TMO_LAST) begin
          state_n = S_DONE;
          done_n  = 1'b1;
          req_n   = 1'b0;
          err_n   = 2'b10;
        end else begin
          wait_n = wait_cnt + 8'd1;
        end
      end

      S_WR: begin
        if (!AL_START) begin
          state_n = S_IDLE;
          done_n  = 1'b1;
          req_n   = 1'b0;
          err_n   = 2'b11;
        end else if (!we_r) begin
          // First Write cycle: issue the strobe for the captured word.
          we_n   = 1'b1;
          cfga_n = idx;
          cfgd_n = data_q;
          cnt_n  = cnt_r + 5'd1;
        end else if (idx == LAST_IDX) begin
          state_n = S_DONE;
          done_n  = 1'b1;
        end else begin
          // Address wraps at 23 bits by construction.
          state_n = S_DAT;
          idx_n   = idx_inc;
          req_n   = 1'b1;
          addr_n  = BASE_ADDR + 23'd1 + {19'd0, idx_inc};
          wait_n  = 8'd0;
        end
      end

      S_DONE: begin
        done_n = 1'b1;
        if (!AL_START) state_n = S_IDLE;
      end

      default: begin
        state_n = S_IDLE;
        done_n  = 1'b1;
        req_n   = 1'b0;
      end
    endcase
  end

  assign AL_DONE  = done_r;
  assign AL_ERR   = err_r;
  assign AL_CNT   = cnt_r;
  assign RD_REQ   = req_r;
  assign RD_ADDR  = addr_r;
  assign CFG_WE   = we_r;
  assign CFG_ADDR = cfga_r;
  assign CFG_DATA = cfgd_r;
  assign AL_STATE = state;

endmodule

// File: tb/tb_auto_load_seq.sv
// Bench for auto_load_seq: table of whole-load scenarios plus hand-written
// abort, mid-load reset and zero-wait latency sequences.
module tb_auto_load_seq;
  localparam int          N     = 8;
  localparam logic [22:0] BASE  = 23'h7E0000;
  localparam logic [15:0] MAGIC = 16'hA55A;
  localparam int          TMO   = 255;

  logic        clk = 1'b0;
  logic        rst, al_start, rd_ack;
  logic [15:0] rd_data;
  logic        al_done, rd_req, cfg_we;
  logic [1:0]  al_err;
  logic [4:0]  al_cnt;
  logic [22:0] rd_addr;
  logic [3:0]  cfg_addr;
  logic [15:0] cfg_data;
  logic [2:0]  al_state;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // BPI model controls
  logic [15:0] hdr_val;
  int          ack_delay, stall_idx, rd_num, wait_n, last_ack_cyc;
  bit          tie_ack;
  int          req_run, last_run;
  logic [22:0] addr_log[$];
  logic [19:0] exp_q[$];

  typedef struct {
    logic [15:0] hdr;
    int          delay;
    int          stall;
    logic [1:0]  err;
    logic [4:0]  cnt;
  } vec_t;
  vec_t vecs[5];

  auto_load_seq #(.NREGS(N), .BASE_ADDR(BASE), .MAGIC(MAGIC), .RD_TMO(TMO)) dut (
    .CLK(clk), .RST(rst), .AL_START(al_start), .AL_DONE(al_done),
    .AL_ERR(al_err), .AL_CNT(al_cnt), .RD_REQ(rd_req), .RD_ADDR(rd_addr),
    .RD_ACK(rd_ack), .RD_DATA(rd_data), .CFG_WE(cfg_we), .CFG_ADDR(cfg_addr),
    .CFG_DATA(cfg_data), .AL_STATE(al_state)
  );

  // clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] pat(input int k);
    logic [3:0] v;
    v = 4'(k + 1);
    return {v, v, v, v};
  endfunction

  function automatic logic [15:0] word_at(input logic [22:0] a);
    logic [22:0] off;
    if (a == BASE) return hdr_val;
    off = a - BASE - 23'd1;
    return pat(int'(off[3:0]));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_done"}, al_done, 1);
    check({tag, "_err"}, al_err, 0);
    check({tag, "_cnt"}, al_cnt, 0);
    check({tag, "_req"}, rd_req, 0);
    check({tag, "_addr"}, rd_addr, 0);
    check({tag, "_we"}, cfg_we, 0);
    check({tag, "_cfga"}, cfg_addr, 0);
    check({tag, "_cfgd"}, cfg_data, 0);
    check({tag, "_state"}, al_state, 0);
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (al_done !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check("done_within_budget", n < budget, 1);
  endtask

  // BPI read engine model: acks after ack_delay cycles, never acks read
  // number stall_idx, or holds ack high when tie_ack is set.
  initial begin
    rd_ack = 1'b0;
    rd_data = 16'd0;
    wait_n = 0;
    last_ack_cyc = 0;
    forever begin
      @(negedge clk);
      if (tie_ack) begin
        rd_ack = 1'b1;
        rd_data = word_at(rd_addr);
      end else if (rd_ack) begin
        rd_ack = 1'b0;
        rd_num++;
        wait_n = 0;
      end else if (rd_req) begin
        if (rd_num != stall_idx && wait_n >= ack_delay) begin
          rd_ack = 1'b1;
          rd_data = word_at(rd_addr);
          last_ack_cyc = cyc;
        end else begin
          wait_n++;
        end
      end else begin
        wait_n = 0;
      end
    end
  end

  // Scoreboard: every config write is popped against the expected queue.
  initial begin
    logic [19:0] exp;
    req_run = 0;
    last_run = 0;
    forever begin
      @(negedge clk);
      #2;
      if (rd_req && rd_ack) addr_log.push_back(rd_addr);
      if (rd_req) req_run++;
      else begin
        if (req_run != 0) last_run = req_run;
        req_run = 0;
      end
      if (cfg_we) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL cfg_write_unexpected: got addr=%0d data=%h expected no write", cfg_addr, cfg_data);
        end else begin
          exp = exp_q.pop_front();
          if ({cfg_addr, cfg_data} !== exp) begin
            failures++;
            $display("FAIL cfg_write: got addr=%0d data=%h expected addr=%0d data=%h",
                     cfg_addr, cfg_data, exp[19:16], exp[15:0]);
          end
        end
      end
    end
  end

  task automatic run_load(input int v);
    hdr_val = vecs[v].hdr;
    ack_delay = vecs[v].delay;
    stall_idx = vecs[v].stall;
    rd_num = 0;
    for (int k = 0; k < int'(vecs[v].cnt); k++) exp_q.push_back({4'(k), pat(k)});
    al_start = 1'b1;
    tick();
    check("start_done_low", al_done, 0);
    check("start_state", al_state, 1);
    check("start_addr", rd_addr, BASE);
    check("start_req", rd_req, 1);
    wait_done(2000);
    check("load_err", al_err, vecs[v].err);
    check("load_cnt", al_cnt, vecs[v].cnt);
    check("load_req_off", rd_req, 0);
    check("load_state_done", al_state, 4);
    if (vecs[v].err == 2'b01) check("bad_hdr_done_latency", cyc - last_ack_cyc, 1);
    repeat (3) tick();
    check("hold_done", al_done, 1);
    check("hold_state", al_state, 4);
    check("writes_all_seen", exp_q.size(), 0);
    if (vecs[v].stall >= 0) check("timeout_req_cycles", last_run, TMO);
    al_start = 1'b0;
    tick();
    check("back_idle", al_state, 0);
    check("idle_err_kept", al_err, vecs[v].err);
    check("idle_cnt_kept", al_cnt, vecs[v].cnt);
    exp_q.delete();
  endtask

  initial begin
    int n;
    rst = 1'b1;
    al_start = 1'b0;
    tie_ack = 1'b0;
    ack_delay = 0;
    stall_idx = -1;
    rd_num = 0;
    hdr_val = MAGIC;
    vecs[0] = '{MAGIC,    3, -1, 2'b00, 5'd8};  // nominal
    vecs[1] = '{16'hFFFF, 1, -1, 2'b01, 5'd0};  // bad header
    vecs[2] = '{MAGIC,    0,  3, 2'b10, 5'd2};  // timeout on 3rd data read
    vecs[3] = '{MAGIC,    2,  0, 2'b10, 5'd0};  // timeout on header read
    vecs[4] = '{16'hA55B, 0, -1, 2'b01, 5'd0};  // header off by one bit

    repeat (3) tick();
    check_reset("reset");
    rst = 1'b0;
    tick();

    for (int v = 0; v < 5; v++) run_load(v);

    // Abort while the 2nd data read is being acked, then restart.
    hdr_val = MAGIC;
    ack_delay = 3;
    stall_idx = -1;
    rd_num = 0;
    exp_q.push_back({4'd0, pat(0)});
    al_start = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!(rd_num == 2 && rd_ack === 1'b1) && n < 500);
    check("abort_point_reached", n < 500, 1);
    al_start = 1'b0;
    tick();
    check("abort_req", rd_req, 0);
    check("abort_state", al_state, 0);
    check("abort_err", al_err, 3);
    check("abort_done", al_done, 1);
    check("abort_cnt", al_cnt, 1);
    repeat (5) tick();
    check("abort_no_more_writes", exp_q.size(), 0);
    rd_num = 0;
    for (int k = 0; k < N; k++) exp_q.push_back({4'(k), pat(k)});
    al_start = 1'b1;
    tick();
    check("restart_state", al_state, 1);
    check("restart_cnt", al_cnt, 0);
    check("restart_err", al_err, 0);
    check("restart_addr", rd_addr, BASE);
    wait_done(2000);
    check("restart_final_cnt", al_cnt, N);
    check("restart_final_err", al_err, 0);
    al_start = 1'b0;
    tick();
    tick();
    check("restart_writes_seen", exp_q.size(), 0);

    // Reset during the write strobe of entry 1.
    ack_delay = 0;
    rd_num = 0;
    for (int k = 0; k < N; k++) exp_q.push_back({4'(k), pat(k)});
    al_start = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!(cfg_we === 1'b1 && cfg_addr == 4'd1) && n < 500);
    check("rst_point_reached", n < 500, 1);
    rst = 1'b1;
    al_start = 1'b0;
    tick();
    check_reset("rst_mid");
    check("rst_writes_before", exp_q.size(), N - 2);
    exp_q.delete();
    rst = 1'b0;
    repeat (10) tick();
    check("rst_after_state", al_state, 0);
    check("rst_after_req", rd_req, 0);

    // Zero-wait acks: latency and address sequence.
    tie_ack = 1'b1;
    tick();
    addr_log.delete();
    for (int k = 0; k < N; k++) exp_q.push_back({4'(k), pat(k)});
    al_start = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (al_done !== 1'b1 && n < 200);
    check("zero_wait_latency", n, 2 + 3 * N);
    check("zero_wait_err", al_err, 0);
    tick();
    check("zero_wait_reads", addr_log.size(), N + 1);
    for (int k = 0; k < addr_log.size(); k++)
      check("zero_wait_addr", addr_log[k], BASE + 23'(k));
    check("zero_wait_writes_seen", exp_q.size(), 0);
    tie_ack = 1'b0;
    al_start = 1'b0;
    repeat (3) tick();
    check("final_idle", al_state, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
